// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of independent integer clock dividers with glitch-free reconfiguration
module clock_divider_bank #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_val,
    output logic              cfg_rdy,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [DIV_W-1:0]  act_div_q  [NUM_CH];
    logic [DIV_W-1:0]  act_div_d  [NUM_CH];
    logic [DIV_W-1:0]  pend_div_q [NUM_CH];
    logic [DIV_W-1:0]  pend_div_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q      [NUM_CH];
    logic [DIV_W-1:0]  cnt_d      [NUM_CH];
    logic [NUM_CH-1:0] act_mode_q, act_mode_d;
    logic [NUM_CH-1:0] pend_mode_q, pend_mode_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] running, boundary, safe_pt, apply, accept;

    always_comb begin
        cfg_rdy = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i) && pend_q[i]) cfg_rdy = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            act_div_d[i]   = act_div_q[i];
            act_mode_d[i]  = act_mode_q[i];
            pend_div_d[i]  = pend_div_q[i];
            pend_mode_d[i] = pend_mode_q[i];
            pend_d[i]      = pend_q[i];
            cnt_d[i]       = '0;
            clk_out_d[i]   = 1'b0;
            tick_d[i]      = 1'b0;

            // A toggle channel that lost its enable keeps running until its high phase ends.
            running[i]  = (act_div_q[i] != '0) &&
                          (en[i] || (!act_mode_q[i] && clk_out_q[i]));
            boundary[i] = running[i] && (cnt_q[i] == act_div_q[i] - DIV_W'(1));
            safe_pt[i]  = !running[i] || (boundary[i] && (act_mode_q[i] || clk_out_q[i]));
            apply[i]    = pend_q[i] && safe_pt[i];
            accept[i]   = cfg_val && cfg_rdy && (cfg_ch == CH_W'(i));

            if (running[i]) begin
                tick_d[i] = boundary[i];
                if (boundary[i]) begin
                    cnt_d[i]     = '0;
                    clk_out_d[i] = act_mode_q[i] ? 1'b1 : !clk_out_q[i];
                end else begin
                    cnt_d[i]     = cnt_q[i] + DIV_W'(1);
                    clk_out_d[i] = act_mode_q[i] ? 1'b0 : clk_out_q[i];
                end
            end

            if (apply[i]) begin
                act_div_d[i]  = pend_div_q[i];
                act_mode_d[i] = pend_mode_q[i];
                pend_d[i]     = 1'b0;
                cnt_d[i]      = '0;
                clk_out_d[i]  = 1'b0;
            end

            // Accept only happens with pend clear, so it never collides with an apply.
            if (accept[i]) begin
                pend_div_d[i]  = cfg_div;
                pend_mode_d[i] = cfg_mode;
                pend_d[i]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_div_q[i]  <= DIV_W'(RESET_DIV);
                pend_div_q[i] <= '0;
                cnt_q[i]      <= '0;
            end
            act_mode_q  <= '0;
            pend_mode_q <= '0;
            pend_q      <= '0;
            clk_out_q   <= '0;
            tick_q      <= '0;
        end else begin
            act_div_q   <= act_div_d;
            pend_div_q  <= pend_div_d;
            cnt_q       <= cnt_d;
            act_mode_q  <= act_mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - self-checking bench for clock_divider_bank
module tb_clock_divider_bank;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           cfg_val;
    logic           cfg_rdy;
    logic [1:0]     cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: m_left counts cycles remaining until the next boundary event.
    int m_div[NCH], m_mode[NCH], m_pdiv[NCH], m_pmode[NCH], m_pend[NCH];
    int m_left[NCH], m_out[NCH], m_tick[NCH];

    clock_divider_bank #(.NUM_CH(NCH), .DIV_W(DW), .RESET_DIV(2)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c] = 2; m_mode[c] = 0; m_pdiv[c] = 0; m_pmode[c] = 0; m_pend[c] = 0;
            m_left[c] = 2; m_out[c] = 0; m_tick[c] = 0;
        end
    endtask

    function automatic int model_rdy();
        return (m_pend[cfg_ch] != 0) ? 0 : 1;
    endfunction

    function automatic int out_vec();
        int v = 0;
        for (int c = 0; c < NCH; c++) v |= m_out[c] << c;
        return v;
    endfunction

    function automatic int tick_vec();
        int v = 0;
        for (int c = 0; c < NCH; c++) v |= m_tick[c] << c;
        return v;
    endfunction

    task automatic model_edge();
        int acc_ok;
        acc_ok = (cfg_val && model_rdy() == 1) ? 1 : 0;
        for (int c = 0; c < NCH; c++) begin
            int act, fire;
            if (m_div[c] == 0) act = 0;
            else act = (en[c] || (m_mode[c] == 0 && m_out[c] == 1)) ? 1 : 0;
            fire = (act == 1 && m_left[c] == 1) ? 1 : 0;
            if (act == 0) begin
                m_out[c] = 0; m_tick[c] = 0; m_left[c] = m_div[c];
            end else if (fire == 1) begin
                m_tick[c] = 1; m_left[c] = m_div[c];
                m_out[c] = (m_mode[c] == 1) ? 1 : ((m_out[c] == 0) ? 1 : 0);
            end else begin
                m_tick[c] = 0; m_left[c] = m_left[c] - 1;
                if (m_mode[c] == 1) m_out[c] = 0;
            end
            if (m_pend[c] == 1 && (act == 0 || (fire == 1 && (m_mode[c] == 1 || m_out[c] == 0)))) begin
                m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c]; m_pend[c] = 0;
                m_left[c] = m_div[c]; m_out[c] = 0;
            end
            if (acc_ok == 1 && int'(cfg_ch) == c) begin
                m_pdiv[c] = int'(cfg_div); m_pmode[c] = int'(cfg_mode); m_pend[c] = 1;
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_eq("cfg_rdy", int'(cfg_rdy), model_rdy());
        if (!reset) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        check_eq("clk_out", int'(clk_out), out_vec());
        check_eq("tick", int'(tick), tick_vec());
    endtask

    task automatic wait_level(input int ch, input logic lvl);
        for (int i = 0; i < 40 && clk_out[ch] != lvl; i++) cycle();
        check_eq("wait_level", int'(clk_out[ch]), int'(lvl));
    endtask

    task automatic measure(input int ch, input logic lvl, output int n);
        n = 0;
        for (int i = 0; i < 40 && clk_out[ch] == lvl; i++) begin
            n++;
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; en = '0; cfg_val = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        model_reset();
        #2;
        check_eq("rst_clk_out", int'(clk_out), 0);
        check_eq("rst_tick", int'(tick), 0);
        check_eq("rst_cfg_rdy", int'(cfg_rdy), 1);
        cycle();
        cycle();
        reset = 1'b1;
        en = 4'hF;

        for (int k = 1; k <= 8; k++) begin
            cycle();
            check_eq("div2_out", int'(clk_out), ((k / 2) % 2 == 1) ? 15 : 0);
            check_eq("div2_tick", int'(tick), (k % 2 == 0) ? 15 : 0);
        end

        cfg_val = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5; cfg_mode = 1'b0;
        cycle();
        cfg_val = 1'b0;
        repeat (6) cycle();
        wait_level(1, 1'b0);
        wait_level(1, 1'b1);
        measure(1, 1'b1, n);
        check_eq("ch1_high_len", n, 5);
        measure(1, 1'b0, n);
        check_eq("ch1_low_len", n, 5);

        cfg_val = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd3; cfg_mode = 1'b1;
        cycle();
        cfg_div = 16'd7;
        #1;
        check_eq("rdy_busy_ch2", int'(cfg_rdy), 0);
        cycle();
        cfg_ch = 2'd3; cfg_div = 16'd0; cfg_mode = 1'b0;
        #1;
        check_eq("rdy_free_ch3", int'(cfg_rdy), 1);
        cycle();
        cfg_val = 1'b0;
        repeat (12) cycle();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n += int'(clk_out[2]);
            check_eq("ch3_idle", int'(clk_out[3]), 0);
        end
        check_eq("ch2_pulses_in_6", n, 2);

        cfg_val = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4; cfg_mode = 1'b0;
        cycle();
        cfg_val = 1'b0;
        repeat (10) cycle();
        wait_level(0, 1'b0);
        wait_level(0, 1'b1);
        en[0] = 1'b0;
        measure(0, 1'b1, n);
        check_eq("ch0_finish_high", n, 4);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n += int'(clk_out[0]);
        end
        check_eq("ch0_parked", n, 0);
        en[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && clk_out[0] == 1'b0; i++) begin
            cycle();
            n++;
        end
        check_eq("ch0_restart_rise", n, 4);

        cfg_val = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3; cfg_mode = 1'b1;
        cycle();
        cfg_val = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_out", int'(clk_out), 0);
        check_eq("async_rst_tick", int'(tick), 0);
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b1;
        cfg_ch = 2'd1;
        #1;
        check_eq("ch1_pend_lost", int'(cfg_rdy), 1);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check_eq("ch1_div2_after_rst", int'(clk_out[1]), (k / 2) % 2);
        end

        for (int t = 0; t < 2500; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(15) == 0) en[c] = ~en[c];
            end
            cfg_val  = ($urandom_range(2) == 0);
            cfg_ch   = 2'($urandom_range(3));
            cfg_div  = 16'($urandom_range(6));
            cfg_mode = 1'($urandom_range(1));
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(499) == 0) begin
                reset = 1'b0;
                model_reset();
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter DIV_W, default 16, width of each channel's divisor.
REQ-003 Parameter RESET_DIV, default 2, divisor loaded into every channel at reset; SHALL satisfy 1 <= RESET_DIV < 2**DIV_W.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  NUM_CH  per-channel run enable.
REQ-007 cfg_val  input  1  config request valid.
REQ-008 cfg_rdy  output  1  config request ready.
REQ-009 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel index.
REQ-010 cfg_div  input  DIV_W  new divisor.
REQ-011 cfg_mode  input  1  new mode: 0 = toggle (50% duty), 1 = pulse (one-cycle strobe).
REQ-012 clk_out  output  NUM_CH  divided outputs, registered.
REQ-013 tick  output  NUM_CH  one-cycle strobe per channel marking each period boundary, registered.

Function
REQ-014 Each channel SHALL hold an active {div, mode}, a pending {div, mode} with pend flag, and a DIV_W-bit counter cnt.
REQ-015 Running (en=1, active div != 0): if cnt == div-1 then cnt <= 0 and boundary event fires, else cnt <= cnt+1.
REQ-016 Toggle mode: clk_out inverts on each boundary event; output period = 2*div clk cycles, high and low phases div cycles each.
REQ-017 Pulse mode: clk_out is 1 for exactly the cycle following each boundary event, else 0; period = div cycles; div=1 gives clk_out constantly 1.
REQ-018 tick SHALL be 1 for the cycle following each boundary event in both modes; 0 otherwise.
REQ-019 Active div == 0: channel idle; cnt held 0, clk_out 0, tick 0.
REQ-020 cfg_rdy = 0 when cfg_ch < NUM_CH and pend[cfg_ch] = 1, else 1 (combinational from cfg_ch).
REQ-021 Accept on cfg_val && cfg_rdy at a rising edge: pending {div, mode} <= {cfg_div, cfg_mode}, pend <= 1; cfg_ch >= NUM_CH accepted and discarded without state change.
REQ-022 Pending values SHALL apply only at a safe point: the cycle of a boundary event whose result leaves clk_out = 0 (toggle mode, phase-high -> low) or any boundary event (pulse mode), or any cycle the channel is idle/parked low; on apply, active <= pending, pend <= 0, cnt <= 0, clk_out <= 0.
REQ-023 No clk_out high or low phase SHALL ever be shorter than min(old div, new div) cycles across a divisor change (glitch-free).
REQ-024 en falling, toggle mode: if clk_out = 1, channel continues counting until its next boundary drives clk_out to 0, then parks (cnt = 0); if clk_out = 0, parks immediately.
REQ-025 en falling, pulse mode: parks next cycle, clk_out = 0, cnt = 0.
REQ-026 en rising from parked: counting starts next cycle from cnt = 0, clk_out = 0; first boundary after div cycles.
REQ-027 Accept and apply on the same channel in the same cycle: the in-flight apply uses the old pending value; the newly accepted value becomes pending (pend stays 1). Cannot arise via REQ-020 unless pend was 0, in which case the new value applies at the following safe point.
REQ-028 Channels SHALL be fully independent; accepting config on one channel SHALL not disturb any other.

Reset
REQ-029 While reset = 0, immediately and asynchronously: cnt = 0, clk_out = 0, tick = 0, pend = 0, active div = RESET_DIV, active mode = 0 for all channels.
REQ-030 Reset asserted mid-operation SHALL discard pending configs; after deassertion channels with en = 1 start per REQ-026 on the first rising clk edge.

Verification
REQ-031 Reset, NUM_CH=4, en=4'b1111, no cfg -> every clk_out toggles every 2 cycles (period 4), tick pulses every 2 cycles.
REQ-032 ch1 cfg_div=5 mode 0 while running div=2 -> applies at next high->low boundary; thereafter high 5, low 5; no phase < 2 cycles observed.
REQ-033 ch2 cfg_div=3 mode 1 -> clk_out[2] one-cycle high every 3 cycles, tick[2] coincident; ch0/ch1/ch3 unchanged.
REQ-034 Second cfg to ch2 while pend[2]=1 -> cfg_rdy=0; cfg to cfg_ch=3 same cycle presented -> cfg_rdy=1 and accepted.
REQ-035 en[0] dropped mid high phase (div=4) -> clk_out[0] finishes its 4-cycle high phase, then stays 0; re-enable -> first rise after 4 cycles.
REQ-036 reset pulled low asynchronously between edges mid-count with pending cfg on ch1 -> all outputs 0 at once; after release ch1 runs at div=2, pending value lost; cfg_div=0 on ch3 -> ch3 idles low.
